matmul_seq: RTL
===============

# matmul_seq

Sequencing controller for `matmul_n` and its result `block_ram`. On a `start` pulse it holds the multiplier in reset, releases it, and waits for `valid`. It then drains all A*C result words from the RAM read port as a valid/ready stream with `last` marking, and reports completion or timeout. It sits between the host/stream side and the `matmul_n` + result RAM pair, and is the sole driver of the multiplier's `rst` and the RAM's read port.

## Interface
- `A`, 16, rows of result matrix
- `C`, 24, columns of result matrix
- `OUT_BITS`, 32, result word width (BITS*4)
- `RST_CYCLES`, 2, cycles `mm_rst` is held in RESET state (>=1)
- `TIMEOUT`, 65535, max cycles in COMPUTE before abort; 0 disables
- Derived: `M3_L` = A*C, `AW` = $clog2(M3_L)
- Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset, sampled on rising `clk`
- `start`  in  1  begin a run; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of run (normal or timeout)
- `err`  out  1  sticky timeout flag; cleared on accepted `start`
- `mm_rst`  out  1  drives `matmul_n` `rst`
- `mm_valid`  in  1  `matmul_n` `valid`
- `m3_rd_addr`  out  AW  result RAM read address
- `m3_rd_data`  in  OUT_BITS  result RAM read data; 1-cycle registered read
- `out_data`  out  OUT_BITS  stream data
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready
- `out_last`  out  1  high with element index M3_L-1

## Operation
- FSM states: IDLE, RESET, COMPUTE, DRAIN, DONE.
- IDLE: `mm_rst`=1. `start`=1 -> RESET, clears `err`, zeroes counters.
- RESET: `mm_rst`=1 for exactly RST_CYCLES cycles, then -> COMPUTE.
- COMPUTE: `mm_rst`=0. Cycle counter increments each cycle.
  - `mm_valid`=1 -> DRAIN.
  - Counter reaches TIMEOUT (TIMEOUT!=0) with no `mm_valid` -> `err`=1, -> DONE.
  - `mm_valid` wins if both occur in the same cycle.
- DRAIN: `mm_rst`=0.
  - Read addresses 0..M3_L-1 are issued in order via `m3_rd_addr`.
  - Results go into a 2-entry FIFO that feeds the stream.
  - A read issues in a cycle only if occupancy + in-flight - pop < 2, where pop = `out_valid`&&`out_ready`. This gives no overflow and full throughput.
  - After element M3_L-1 is accepted -> DONE.
- DONE: single cycle, `done`=1, -> IDLE. The DONE -> IDLE cycle does not sample `start`.
- Stream rules:
  - `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a transfer.
  - Exactly M3_L transfers per successful run; none after a timeout.
- `start` while busy is ignored.
- `m3_rd_addr` holds its last value when no read is issued. Its value is don't-care outside DRAIN.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `mm_rst`=1, `out_valid`=0, `out_last`=0, `m3_rd_addr`=0, FIFO empty, counters 0.
- `rst` mid-run aborts immediately to IDLE with the reset values above. In-flight data is discarded.
- Cycle numbering: `start` is sampled at edge 0.
  - RESET occupies cycles 1..RST_CYCLES.
  - `mm_rst` first reads 0 in cycle RST_CYCLES+1.
- Drain latency: if `mm_valid` is sampled at edge k, the first read issues in cycle k+1 (address 0) and `out_valid` first rises in cycle k+3.
- Read issued in cycle t: data is valid in t+1, captured at end of t+1, presented on the stream from t+2.
- With `out_ready` held high, one element transfers per cycle; the last transfer is in cycle k+M3_L+2 and `done` is high in the following cycle.
- Timeout: `done`=1 and `err`=1 in the cycle after the counter hits TIMEOUT.

## Test plan
- Nominal run: default params, memh-loaded A/B, `out_ready`=1.
  - 384 words stream in address order and match c.memh.
  - `out_last` only on word 383.
  - Exactly one `done` pulse; `err`=0.
- Backpressure: `out_ready` toggled in a pseudo-random pattern (about 50%).
  - Identical 384-word sequence; no drops or duplicates.
  - Data held stable while stalled; FIFO never exceeds 2 entries.
- Reset sequencing: RST_CYCLES=3.
  - `mm_rst` high in exactly cycles 1..3 after `start`, low from cycle 4 until DONE.
  - `start` pulses during `busy` have no effect.
- Timeout: TIMEOUT=10, `mm_valid` tied 0.
  - `done`=1 and `err`=1 eleven cycles after COMPUTE entry; no stream transfers.
  - Next `start` clears `err`.
- Mid-drain reset: assert `rst` after 100 transfers.
  - All outputs return to reset values on the next cycle.
  - A subsequent full run passes the nominal checks.
- Throughput: `out_ready`=1 throughout.
  - Last transfer exactly 386 cycles after the `mm_valid` sample edge.

Source files
------------

// File: rtl/matmul_seq.sv
// rtl/matmul_seq.sv - run sequencer for matmul_n and its result RAM
//
// Ports:
//   clk, rst       sole clock, synchronous active-high reset
//   start          begin a run (sampled only while idle)
//   busy           high whenever a run is in progress
//   done           one-cycle pulse at the end of a run (normal or timeout)
//   err            sticky timeout flag, cleared by an accepted start
//   mm_rst         reset to matmul_n
//   mm_valid       matmul_n result-ready indication
//   m3_rd_addr     result RAM read address
//   m3_rd_data     result RAM read data (one-cycle registered read)
//   out_data/out_valid/out_ready/out_last   result stream
module matmul_seq #(
    parameter int A          = 16,
    parameter int C          = 24,
    parameter int OUT_BITS   = 32,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 65535,
    localparam int M3_L      = A * C,
    localparam int AW        = $clog2(M3_L)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mm_rst,
    input  logic                mm_valid,
    output logic [AW-1:0]       m3_rd_addr,
    input  logic [OUT_BITS-1:0] m3_rd_data,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [RCW-1:0]      r_rst_cnt;
    logic [TCW-1:0]      r_cyc_cnt;
    logic                r_err;
    logic [AW-1:0]       r_rd_addr;
    logic                r_issue_done;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [OUT_BITS-1:0] r_fifo_data [2];
    logic                r_fifo_last [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic w_pop;
    logic w_issue;
    logic w_timeout;
    logic w_rst_last;
    logic w_last_pop;
    logic w_start_ok;

    assign w_pop      = (r_count != 2'd0) && out_ready;
    assign w_last_pop = w_pop && r_fifo_last[r_rd_ptr];
    assign w_timeout  = (TIMEOUT != 0) && (r_cyc_cnt == TCW'(TIMEOUT));
    assign w_rst_last = (r_rst_cnt == RCW'(RST_CYCLES - 1));
    assign w_start_ok = (r_state == S_IDLE) && start;

    // Issue only when the word cannot overflow the 2-entry FIFO, counting the
    // read already in flight and crediting a pop happening this cycle.
    assign w_issue = (r_state == S_DRAIN) && !r_issue_done &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_RESET;
            S_RESET:   if (w_rst_last) w_next_state = S_COMPUTE;
            S_COMPUTE: begin
                // A valid arriving on the timeout cycle still wins.
                if (mm_valid)       w_next_state = S_DRAIN;
                else if (w_timeout) w_next_state = S_DONE;
            end
            S_DRAIN:   if (w_last_pop) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        mm_rst = (r_state == S_IDLE) || (r_state == S_RESET);
    end

    assign err        = r_err;
    assign m3_rd_addr = r_rd_addr;
    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_fifo_data[r_rd_ptr];
    assign out_last   = out_valid && r_fifo_last[r_rd_ptr];

    // Counters, read issue and result FIFO
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_rst_cnt       <= '0;
            r_cyc_cnt       <= '0;
            r_err           <= 1'b0;
            r_rd_addr       <= '0;
            r_issue_done    <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            if (r_state == S_RESET) begin
                r_rst_cnt <= r_rst_cnt + RCW'(1);
            end
            if (r_state == S_COMPUTE) begin
                if (TIMEOUT != 0 && !w_timeout) begin
                    r_cyc_cnt <= r_cyc_cnt + TCW'(1);
                end
                if (!mm_valid && w_timeout) begin
                    r_err <= 1'b1;
                end
            end

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == AW'(M3_L - 1));
            if (w_issue) begin
                // Address parks on the final word instead of wrapping.
                if (r_rd_addr == AW'(M3_L - 1)) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_rd_addr <= r_rd_addr + AW'(1);
                end
            end

            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= m3_rd_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
